// File: rtl/branch_predictor.sv
// branch_predictor
//   Dynamic branch predictor and redirect unit for the LC-3b pipeline.
//   A direct-mapped BTB with per-entry saturating counters gives fetch a
//   same-cycle taken/target prediction. Resolved branches update the tables.
//   A mispredict produces a registered one-cycle flush and a redirect address.
//   Saturating statistics count resolved branches and mispredicts.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   if_valid, if_pc   fetch lookup request
//   pred_taken        combinational prediction for if_pc
//   pred_target       combinational predicted next fetch address
//   res_valid, res_pc, res_taken, res_target
//                     outcome of the instruction resolved this cycle
//   res_pred_taken, res_pred_target
//                     prediction that the resolved instruction carried
//   flush, redirect_pc
//                     registered flush pulse and its redirect address
//   branch_count, mispredict_count
//                     saturating statistics
module branch_predictor #(
  parameter int WIDTH     = 16,
  parameter int ENTRIES   = 16,
  parameter int CTR_BITS  = 2,
  parameter int STAT_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 if_valid,
  input  logic [WIDTH-1:0]     if_pc,
  output logic                 pred_taken,
  output logic [WIDTH-1:0]     pred_target,
  input  logic                 res_valid,
  input  logic [WIDTH-1:0]     res_pc,
  input  logic                 res_taken,
  input  logic [WIDTH-1:0]     res_target,
  input  logic                 res_pred_taken,
  input  logic [WIDTH-1:0]     res_pred_target,
  output logic                 flush,
  output logic [WIDTH-1:0]     redirect_pc,
  output logic [STAT_BITS-1:0] branch_count,
  output logic [STAT_BITS-1:0] mispredict_count
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = WIDTH - IDX - 1;

  localparam logic [CTR_BITS-1:0] CTR_WEAK_NT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_WEAK_T  = CTR_BITS'(1 << (CTR_BITS - 1));

  function automatic logic [CTR_BITS-1:0] ctr_sat_inc(input logic [CTR_BITS-1:0] c);
    return (&c) ? c : c + CTR_BITS'(1);
  endfunction

  function automatic logic [CTR_BITS-1:0] ctr_sat_dec(input logic [CTR_BITS-1:0] c);
    return (c == '0) ? c : c - CTR_BITS'(1);
  endfunction

  function automatic logic [STAT_BITS-1:0] stat_sat_inc(input logic [STAT_BITS-1:0] s);
    return (&s) ? s : s + STAT_BITS'(1);
  endfunction

  logic                valid_q  [ENTRIES];
  logic [TAG_W-1:0]    tag_q    [ENTRIES];
  logic [WIDTH-1:0]    target_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q    [ENTRIES];

  // Instruction addresses are halfword aligned, so bit 0 never selects anything.
  logic unused_pc_lsb;
  assign unused_pc_lsb = if_pc[0] ^ res_pc[0];

  // Lookup: reads current state only, so a same-cycle update is not visible.
  logic [IDX-1:0]   if_idx;
  logic [TAG_W-1:0] if_tag;
  logic             if_hit;

  assign if_idx      = if_pc[IDX:1];
  assign if_tag      = if_pc[WIDTH-1:IDX+1];
  assign if_hit      = if_valid & valid_q[if_idx] & (tag_q[if_idx] == if_tag);
  assign pred_taken  = if_hit & ctr_q[if_idx][CTR_BITS-1];
  assign pred_target = pred_taken ? target_q[if_idx] : if_pc + WIDTH'(2);

  // Resolve side
  logic [IDX-1:0]   res_idx;
  logic [TAG_W-1:0] res_tag;
  logic             res_hit;
  logic             mispredict;
  logic             upd;

  assign res_idx    = res_pc[IDX:1];
  assign res_tag    = res_pc[WIDTH-1:IDX+1];
  assign res_hit    = valid_q[res_idx] & (tag_q[res_idx] == res_tag);
  assign mispredict = (res_taken != res_pred_taken) |
                      (res_taken & res_pred_taken & (res_target != res_pred_target));
  assign upd        = res_valid & ~reset;

  // Control state: valid bits, counters, flush/redirect and statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_WEAK_NT;
      end
      flush            <= 1'b0;
      redirect_pc      <= '0;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      flush <= res_valid & mispredict;
      if (res_valid) begin
        branch_count <= stat_sat_inc(branch_count);
        if (mispredict) begin
          mispredict_count <= stat_sat_inc(mispredict_count);
          redirect_pc      <= res_taken ? res_target : res_pc + WIDTH'(2);
        end
        if (res_hit) begin
          ctr_q[res_idx] <= res_taken ? ctr_sat_inc(ctr_q[res_idx])
                                      : ctr_sat_dec(ctr_q[res_idx]);
        end else if (res_taken) begin
          valid_q[res_idx] <= 1'b1;
          ctr_q[res_idx]   <= CTR_WEAK_T;
        end
      end
    end
  end

  // Data arrays: only meaningful behind a valid bit, so they carry no reset.
  always_ff @(posedge clk) begin
    if (upd && res_taken) begin
      target_q[res_idx] <= res_target;
      if (!res_hit) begin
        tag_q[res_idx] <= res_tag;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  localparam int W  = 16;
  localparam int N  = 16;
  localparam int CB = 2;
  localparam int SB = 16;
  localparam int CTR_MAX  = (1 << CB) - 1;
  localparam int STAT_MAX = (1 << SB) - 1;
  localparam int ADDR_MOD = 1 << W;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_valid;
  logic [W-1:0]  if_pc;
  logic          pred_taken;
  logic [W-1:0]  pred_target;
  logic          res_valid;
  logic [W-1:0]  res_pc;
  logic          res_taken;
  logic [W-1:0]  res_target;
  logic          res_pred_taken;
  logic [W-1:0]  res_pred_target;
  logic          flush;
  logic [W-1:0]  redirect_pc;
  logic [SB-1:0] branch_count;
  logic [SB-1:0] mispredict_count;

  branch_predictor #(
    .WIDTH(W), .ENTRIES(N), .CTR_BITS(CB), .STAT_BITS(SB)
  ) dut (
    .clk(clk), .reset(reset),
    .if_valid(if_valid), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .res_valid(res_valid), .res_pc(res_pc), .res_taken(res_taken),
    .res_target(res_target), .res_pred_taken(res_pred_taken),
    .res_pred_target(res_pred_target),
    .flush(flush), .redirect_pc(redirect_pc),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the BTB as plain integer arrays, updated by the rules.
  bit m_valid [N];
  int m_tag   [N];
  int m_tgt   [N];
  int m_ctr   [N];
  bit m_flush;
  int m_redir;
  int m_bc;
  int m_mc;
  bit model_on = 1'b0;

  int u_pc, u_idx, u_tag;
  bit u_hit, u_mis;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        m_valid[i] = 1'b0;
        m_ctr[i]   = (1 << (CB - 1)) - 1;
      end
      m_flush  = 1'b0;
      m_redir  = 0;
      m_bc     = 0;
      m_mc     = 0;
      model_on = 1'b1;
    end else begin
      m_flush = 1'b0;
      if (res_valid) begin
        u_pc  = int'(res_pc);
        u_idx = (u_pc / 2) % N;
        u_tag = u_pc / (2 * N);
        u_hit = m_valid[u_idx] && (m_tag[u_idx] == u_tag);
        u_mis = (res_taken != res_pred_taken) ||
                (res_taken && (res_target != res_pred_target));
        if (u_hit) begin
          if (res_taken) begin
            if (m_ctr[u_idx] < CTR_MAX) m_ctr[u_idx] = m_ctr[u_idx] + 1;
            m_tgt[u_idx] = int'(res_target);
          end else if (m_ctr[u_idx] > 0) begin
            m_ctr[u_idx] = m_ctr[u_idx] - 1;
          end
        end else if (res_taken) begin
          m_valid[u_idx] = 1'b1;
          m_tag[u_idx]   = u_tag;
          m_tgt[u_idx]   = int'(res_target);
          m_ctr[u_idx]   = 1 << (CB - 1);
        end
        if (m_bc < STAT_MAX) m_bc = m_bc + 1;
        if (u_mis) begin
          if (m_mc < STAT_MAX) m_mc = m_mc + 1;
          m_flush = 1'b1;
          m_redir = res_taken ? int'(res_target) : (u_pc + 2) % ADDR_MOD;
        end
      end
    end
  end

  int l_pc, l_idx, l_tag, e_taken, e_tgt;

  always @(negedge clk) begin
    if (model_on) begin
      l_pc  = int'(if_pc);
      l_idx = (l_pc / 2) % N;
      l_tag = l_pc / (2 * N);
      e_taken = (if_valid && m_valid[l_idx] && m_tag[l_idx] == l_tag &&
                 m_ctr[l_idx] >= (1 << (CB - 1))) ? 1 : 0;
      e_tgt = e_taken ? m_tgt[l_idx] : (l_pc + 2) % ADDR_MOD;
      check("mdl_pred_taken", int'(pred_taken), e_taken);
      check("mdl_pred_target", int'(pred_target), e_tgt);
      check("mdl_flush", int'(flush), int'(m_flush));
      if (m_flush) check("mdl_redirect_pc", int'(redirect_pc), m_redir);
      check("mdl_branch_count", int'(branch_count), m_bc);
      check("mdl_mispredict_count", int'(mispredict_count), m_mc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resolve(input logic [W-1:0] pc, input logic tk, input logic [W-1:0] tgt,
                         input logic ptk, input logic [W-1:0] ptgt);
    res_valid       = 1'b1;
    res_pc          = pc;
    res_taken       = tk;
    res_target      = tgt;
    res_pred_taken  = ptk;
    res_pred_target = ptgt;
  endtask

  initial begin
    reset = 1'b1; if_valid = 1'b0; if_pc = '0;
    res_valid = 1'b0; res_pc = '0; res_taken = 1'b0; res_target = '0;
    res_pred_taken = 1'b0; res_pred_target = '0;
    tick(); tick();
    reset = 1'b0;

    // Reset state and cold lookup
    if_valid = 1'b1; if_pc = 16'h3000;
    @(negedge clk);
    check("cold_pred_taken", int'(pred_taken), 0);
    check("cold_pred_target", int'(pred_target), 16'h3002);
    check("reset_branch_count", int'(branch_count), 0);
    check("reset_mispredict_count", int'(mispredict_count), 0);
    check("reset_flush", int'(flush), 0);
    check("reset_redirect", int'(redirect_pc), 0);

    // Taken mispredict allocates the entry
    resolve(16'h3000, 1'b1, 16'h3100, 1'b0, 16'h3002);
    tick(); res_valid = 1'b0;
    @(negedge clk);
    check("alloc_flush", int'(flush), 1);
    check("alloc_redirect", int'(redirect_pc), 16'h3100);
    check("alloc_mispredict_count", int'(mispredict_count), 1);
    tick();
    @(negedge clk);
    check("alloc_flush_drop", int'(flush), 0);
    check("alloc_redirect_hold", int'(redirect_pc), 16'h3100);
    check("alloc_pred_taken", int'(pred_taken), 1);
    check("alloc_pred_target", int'(pred_target), 16'h3100);

    // Three not-taken resolves saturate the counter at zero
    for (int k = 0; k < 3; k++) begin
      resolve(16'h3000, 1'b0, 16'h0000, 1'b1, 16'h3100);
      tick();
      @(negedge clk);
      check("nt_flush", int'(flush), 1);
      check("nt_redirect", int'(redirect_pc), 16'h3002);
    end
    res_valid = 1'b0;
    tick();
    @(negedge clk);
    check("nt_pred_taken", int'(pred_taken), 0);
    check("nt_pred_target", int'(pred_target), 16'h3002);

    // Alias at index 0 evicts 0x3000
    resolve(16'h3020, 1'b1, 16'h3500, 1'b0, 16'h3022);
    tick(); res_valid = 1'b0;
    @(negedge clk);
    check("alias_old_pred_taken", int'(pred_taken), 0);
    check("alias_old_pred_target", int'(pred_target), 16'h3002);
    if_pc = 16'h3020; #1;
    check("alias_new_pred_taken", int'(pred_taken), 1);
    check("alias_new_pred_target", int'(pred_target), 16'h3500);

    // Same-cycle lookup and update: read before write
    @(negedge clk);
    if_pc = 16'h4000;
    resolve(16'h4000, 1'b1, 16'h4400, 1'b0, 16'h4002);
    #1;
    check("rbw_pred_taken", int'(pred_taken), 0);
    check("rbw_pred_target", int'(pred_target), 16'h4002);
    tick(); res_valid = 1'b0;
    @(negedge clk);
    check("rbw_after_pred_taken", int'(pred_taken), 1);
    check("rbw_after_pred_target", int'(pred_target), 16'h4400);

    // Address wrap on lookup and redirect
    if_pc = 16'hFFFE; #1;
    check("wrap_pred_target", int'(pred_target), 16'h0000);
    resolve(16'hFFFE, 1'b0, 16'h0000, 1'b1, 16'h1234);
    tick(); res_valid = 1'b0;
    @(negedge clk);
    check("wrap_redirect", int'(redirect_pc), 16'h0000);

    // Right direction, wrong target
    if_pc = 16'h4000;
    resolve(16'h4000, 1'b1, 16'h4800, 1'b1, 16'h4400);
    tick();
    @(negedge clk);
    check("tgt_mis_flush", int'(flush), 1);
    check("tgt_mis_redirect", int'(redirect_pc), 16'h4800);
    // Correct prediction: no flush, redirect holds
    resolve(16'h4000, 1'b1, 16'h4800, 1'b1, 16'h4800);
    tick(); res_valid = 1'b0;
    @(negedge clk);
    check("correct_flush", int'(flush), 0);
    check("correct_redirect_hold", int'(redirect_pc), 16'h4800);
    check("mid_branch_count", int'(branch_count), 9);
    check("mid_mispredict_count", int'(mispredict_count), 8);

    // Saturate branch_count with correctly predicted not-taken misses
    resolve(16'h5000, 1'b0, 16'h0000, 1'b0, 16'h5002);
    repeat (65530) @(posedge clk);
    #1;
    @(negedge clk);
    check("sat_branch_count", int'(branch_count), 16'hFFFF);
    check("sat_mispredict_count", int'(mispredict_count), 8);
    tick();
    @(negedge clk);
    check("sat_branch_count_hold", int'(branch_count), 16'hFFFF);

    // Reset dominates a mispredicting resolve
    reset = 1'b1;
    if_pc = 16'h4000;
    resolve(16'h4000, 1'b0, 16'h0000, 1'b1, 16'h4800);
    tick();
    reset = 1'b0; res_valid = 1'b0;
    @(negedge clk);
    check("rst_flush", int'(flush), 0);
    check("rst_redirect", int'(redirect_pc), 0);
    check("rst_branch_count", int'(branch_count), 0);
    check("rst_mispredict_count", int'(mispredict_count), 0);
    check("rst_pred_taken", int'(pred_taken), 0);
    check("rst_pred_target", int'(pred_target), 16'h4002);

    // Lookups disabled never predict taken
    if_valid = 1'b0;
    resolve(16'h6000, 1'b1, 16'h6200, 1'b0, 16'h6002);
    tick(); res_valid = 1'b0;
    if_pc = 16'h6000; #1;
    check("noval_pred_taken", int'(pred_taken), 0);
    check("noval_pred_target", int'(pred_target), 16'h6002);
    if_valid = 1'b1; #1;
    check("val_pred_taken", int'(pred_taken), 1);
    check("val_pred_target", int'(pred_target), 16'h6200);
    tick();
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
